// File: rtl/alu_result_stage_if.sv
// Result-stage handshake bundle: upstream ALU result port and downstream flagged-result port.
interface alu_result_stage_if #(
   parameter int WIDTH = 24
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             carry_in;
   logic             ovf_in;
   logic [2:0]       selector;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             ovf;
   logic             illegal_op;

   modport master (
      output in_valid, result, carry_in, ovf_in, selector, out_ready,
      input  in_ready, out_valid, out_result, zero, negative, carry, ovf, illegal_op
   );

   modport slave (
      input  in_valid, result, carry_in, ovf_in, selector, out_ready,
      output in_ready, out_valid, out_result, zero, negative, carry, ovf, illegal_op
   );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flags derived at accept, two-entry skid buffer toward writeback.
// Optional sticky overflow accumulator enabled by defining ALU_STICKY_OVF_EN.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no entry held, in_ready = 1
// ST_ONE   | main holds the head entry, in_ready = 1
// ST_TWO   | main is head, skid holds the next, in_ready = 0
module alu_result_stage #(
   parameter int WIDTH = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_result_stage_if.slave io,
   input  logic              clear_ovf,
   output logic              sticky_ovf
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef struct packed {
      logic             illegal;
      logic             ovf;
      logic             carry;
      logic             negative;
      logic             zero;
      logic [WIDTH-1:0] res;
   } entry_t;

   logic [1:0] state_q, state_d;
   logic       in_ready_q;
   entry_t     main_q, skid_q, in_entry;
   logic       out_valid, accept, pop, arith_op;
   logic       load_main, load_skid, move_skid;

   // Only add and subtract/less carry meaningful adder flags
   assign arith_op = (io.selector == 3'b010) || (io.selector == 3'b011);

   always_comb begin
      in_entry          = '0;
      in_entry.res      = io.result;
      in_entry.zero     = (io.result == '0);
      in_entry.negative = io.result[WIDTH-1];
      in_entry.carry    = arith_op & io.carry_in;
      in_entry.ovf      = arith_op & io.ovf_in;
      in_entry.illegal  = io.selector[2];
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = io.in_valid & in_ready_q;
   assign pop       = out_valid & io.out_ready;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (pop) begin
               state_d   = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               state_d   = ST_ONE;
               move_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         // Ready is registered from the next state so it never depends on out_ready combinationally
         in_ready_q <= (state_d != ST_TWO);
         if (load_main) begin
            main_q <= in_entry;
         end else if (move_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   assign io.in_ready   = in_ready_q;
   assign io.out_valid  = out_valid;
   assign io.out_result = main_q.res;
   assign io.zero       = main_q.zero;
   assign io.negative   = main_q.negative;
   assign io.carry      = main_q.carry;
   assign io.ovf        = main_q.ovf;
   assign io.illegal_op = main_q.illegal;

`ifdef ALU_STICKY_OVF_EN
   logic sticky_q;

   // A set from an overflowing pop takes priority over a clear in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (pop && main_q.ovf) begin
         sticky_q <= 1'b1;
      end else if (clear_ovf) begin
         sticky_q <= 1'b0;
      end
   end

   assign sticky_ovf = sticky_q;
`else
   logic unused_clear_ovf;

   assign unused_clear_ovf = clear_ovf;
   assign sticky_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic against a queue-based model.
module tb_alu_result_stage;
   localparam int W = 24;

   typedef struct packed {
      logic         illegal;
      logic         ovf;
      logic         carry;
      logic         neg;
      logic         zero;
      logic [W-1:0] res;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear_ovf = 1'b0;
   logic sticky_ovf;

   int   checks = 0;
   int   passes = 0;
   int   acc_count = 0;
   logic last_acc = 1'b0;
   logic sticky_m = 1'b0;
   ent_t q[$];

   always #5 clk = ~clk;

   alu_result_stage_if #(.WIDTH(W)) ifc ();

   alu_result_stage #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (ifc),
      .clear_ovf  (clear_ovf),
      .sticky_ovf (sticky_ovf)
   );

   function automatic ent_t expect_of(logic [W-1:0] r, logic c, logic o, logic [2:0] s);
      ent_t e;
      logic is_arith;
      is_arith  = (s == 3'd2) || (s == 3'd3);
      e.res     = r;
      e.zero    = (r == 0);
      e.neg     = r[W-1];
      e.carry   = is_arith ? c : 1'b0;
      e.ovf     = is_arith ? o : 1'b0;
      e.illegal = (s >= 3'd4);
      return e;
   endfunction

   function automatic ent_t observed();
      ent_t e;
      e.res     = ifc.out_result;
      e.zero    = ifc.zero;
      e.neg     = ifc.negative;
      e.carry   = ifc.carry;
      e.ovf     = ifc.ovf;
      e.illegal = ifc.illegal_op;
      return e;
   endfunction

   task automatic drive(logic v, logic [W-1:0] r, logic c, logic o, logic [2:0] s, logic rdy);
      ifc.in_valid  = v;
      ifc.result    = r;
      ifc.carry_in  = c;
      ifc.ovf_in    = o;
      ifc.selector  = s;
      ifc.out_ready = rdy;
   endtask

   // Advance one clock and update the model with what the stage should have done at that edge
   task automatic tick();
      logic acc, pp;
      ent_t ne;
      acc = ifc.in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && ifc.out_ready;
      ne  = expect_of(ifc.result, ifc.carry_in, ifc.ovf_in, ifc.selector);
      @(posedge clk);
`ifdef ALU_STICKY_OVF_EN
      if (pp && q[0].ovf) sticky_m = 1'b1;
      else if (clear_ovf) sticky_m = 1'b0;
`endif
      if (pp) void'(q.pop_front());
      if (acc) begin
         q.push_back(ne);
         acc_count++;
      end
      last_acc = acc;
      #1;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0, 3'd0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ifc.out_valid, ifc.in_ready, observed(), sticky_ovf} !== {1'b0, 1'b1, ent_t'(0), 1'b0})
         $display("FAIL reset_initial: got v=%b r=%b e=%h s=%b, want v=0 r=1 e=0 s=0",
                  ifc.out_valid, ifc.in_ready, observed(), sticky_ovf);
      else passes++;
      rst_n = 1'b1;
      drive(1, 24'h800001, 1, 1, 3'b010, 0);
      tick();
      drive(1, 24'h123456, 1, 1, 3'b011, 0);
      tick();
      drive(0, '0, 0, 0, 3'd0, 0);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0)
         $display("FAIL reset_prefill: got v=%b r=%b, want v=1 r=0", ifc.out_valid, ifc.in_ready);
      else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      sticky_m = 1'b0;
      checks++;
      if ({ifc.out_valid, ifc.in_ready} !== 2'b01)
         $display("FAIL reset_mid_handshake: got v=%b r=%b, want v=0 r=1", ifc.out_valid, ifc.in_ready);
      else passes++;
      checks++;
      if (observed() !== ent_t'(0))
         $display("FAIL reset_mid_outputs: got %h, want 0", observed());
      else passes++;
      checks++;
      if (sticky_ovf !== 1'b0)
         $display("FAIL reset_mid_sticky: got %b, want 0", sticky_ovf);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero();
      drive(1, 24'h000000, 1, 1, 3'b000, 0);
      tick();
      drive(0, '0, 0, 0, 3'd0, 0);
      checks++;
      if ({ifc.out_valid, ifc.zero, ifc.carry, ifc.ovf, ifc.illegal_op} !== 5'b11000)
         $display("FAIL zero_flags: got v=%b z=%b c=%b o=%b i=%b, want 1 1 0 0 0",
                  ifc.out_valid, ifc.zero, ifc.carry, ifc.ovf, ifc.illegal_op);
      else passes++;
      tick();
      checks++;
      if (observed() !== q[0])
         $display("FAIL zero_hold: got %h, want %h", observed(), q[0]);
      else passes++;
      ifc.out_ready = 1'b1;
      tick();
      checks++;
      if (ifc.out_valid !== 1'b0)
         $display("FAIL zero_drain: got v=%b, want 0", ifc.out_valid);
      else passes++;
   endtask

   task automatic test_flags();
      logic [W-1:0] rv [4] = '{24'h800000, 24'h800000, 24'h7fffff, 24'h000001};
      logic [2:0]   sv [4] = '{3'b010, 3'b001, 3'b011, 3'b110};
      logic         cv [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      logic         ov [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [3:0]   xv [4] = '{4'b1110, 4'b1000, 4'b0100, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         drive(1, rv[i], cv[i], ov[i], sv[i], 1);
         tick();
         checks++;
         if ({ifc.out_valid, ifc.negative, ifc.carry, ifc.ovf, ifc.illegal_op} !== {1'b1, xv[i]} ||
             ifc.out_result !== rv[i])
            $display("FAIL flags_%0d: got v=%b n=%b c=%b o=%b i=%b r=%h, want v=1 nco i=%b r=%h", i,
                     ifc.out_valid, ifc.negative, ifc.carry, ifc.ovf, ifc.illegal_op,
                     ifc.out_result, xv[i], rv[i]);
         else passes++;
      end
      drive(0, '0, 0, 0, 3'd0, 1);
      tick();
      checks++;
      if (ifc.out_valid !== 1'b0 || q.size() != 0)
         $display("FAIL flags_drain: got v=%b, want 0", ifc.out_valid);
      else passes++;
   endtask

   task automatic test_skid();
      logic [W-1:0] a, b, c;
      logic [W-1:0] got[$];
      int start_acc;
      int cyc;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      start_acc = acc_count;
      drive(1, a, 0, 0, 3'b000, 0);
      tick();
      drive(1, b, 0, 0, 3'b000, 0);
      tick();
      drive(1, c, 0, 0, 3'b000, 0);
      checks++;
      if (ifc.in_ready !== 1'b0 || ifc.out_result !== a)
         $display("FAIL skid_full: got r=%b head=%h, want r=0 head=%h", ifc.in_ready, ifc.out_result, a);
      else passes++;
      tick();
      tick();
      checks++;
      if (acc_count != start_acc + 2 || ifc.out_result !== a || ifc.in_ready !== 1'b0)
         $display("FAIL skid_stall: got head=%h r=%b, want head=%h r=0", ifc.out_result, ifc.in_ready, a);
      else passes++;
      ifc.out_ready = 1'b1;
      cyc = 0;
      while (got.size() < 3 && cyc < 12) begin
         if (ifc.out_valid) got.push_back(ifc.out_result);
         tick();
         if (last_acc) ifc.in_valid = 1'b0;
         cyc++;
      end
      checks++;
      if (got.size() != 3)
         $display("FAIL skid_timeout: got %0d outputs, want 3", got.size());
      else if (got[0] !== a || got[1] !== b || got[2] !== c)
         $display("FAIL skid_order: got %h %h %h, want %h %h %h", got[0], got[1], got[2], a, b, c);
      else passes++;
      drive(0, '0, 0, 0, 3'd0, 1);
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] base;
      logic [W-1:0] got[$];
      int first, last;
      base = W'($urandom);
      first = -1; last = -1;
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (ifc.in_ready !== 1'b1)
            $display("FAIL b2b_ready_%0d: got %b, want 1", i, ifc.in_ready);
         else passes++;
         if (ifc.out_valid) begin
            got.push_back(ifc.out_result);
            if (first < 0) first = i;
            last = i;
         end
         if (i < 10) drive(1, base + W'(i), 0, 0, 3'b001, 1);
         else drive(0, '0, 0, 0, 3'd0, 1);
         tick();
      end
      checks++;
      if (got.size() != 10 || last - first != 9)
         $display("FAIL b2b_count: got %0d outputs over %0d cycles, want 10 over 10",
                  got.size(), last - first + 1);
      else passes++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== base + W'(i))
            $display("FAIL b2b_data_%0d: got %h, want %h", i, got[i], base + W'(i));
         else passes++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 7) == 0 ? 0 : $urandom),
               1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0));
         clear_ovf = 1'($urandom_range(0, 7) == 0);
         tick();
         checks++;
         if ({ifc.out_valid, ifc.in_ready} !== {q.size() > 0, q.size() < 2})
            $display("FAIL rand_handshake_%0d: got v=%b r=%b, want v=%b r=%b", i,
                     ifc.out_valid, ifc.in_ready, q.size() > 0, q.size() < 2);
         else passes++;
         if (q.size() > 0) begin
            checks++;
            if (observed() !== q[0])
               $display("FAIL rand_head_%0d: got %h, want %h", i, observed(), q[0]);
            else passes++;
         end
         checks++;
         if (sticky_ovf !== sticky_m)
            $display("FAIL rand_sticky_%0d: got %b, want %b", i, sticky_ovf, sticky_m);
         else passes++;
      end
      clear_ovf = 1'b0;
      drive(0, '0, 0, 0, 3'd0, 1);
      tick();
      tick();
      tick();
   endtask

   task automatic test_sticky();
      logic exp_s [5];
`ifdef ALU_STICKY_OVF_EN
      exp_s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
      exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      clear_ovf = 1'b1;
      drive(0, '0, 0, 0, 3'd0, 0);
      tick();
      clear_ovf = 1'b0;
      drive(1, 24'h400000, 1, 1, 3'b010, 0);
      tick();
      drive(1, 24'h000010, 0, 0, 3'b000, 0);
      tick();
      checks++;
      if (sticky_ovf !== exp_s[0])
         $display("FAIL sticky_idle: got %b, want %b", sticky_ovf, exp_s[0]);
      else passes++;
      drive(0, '0, 0, 0, 3'd0, 1);
      tick();
      checks++;
      if (sticky_ovf !== exp_s[1])
         $display("FAIL sticky_set: got %b, want %b", sticky_ovf, exp_s[1]);
      else passes++;
      drive(1, 24'h000020, 1, 1, 3'b011, 1);
      tick();
      checks++;
      if (sticky_ovf !== exp_s[2])
         $display("FAIL sticky_persist: got %b, want %b", sticky_ovf, exp_s[2]);
      else passes++;
      drive(0, '0, 0, 0, 3'd0, 1);
      clear_ovf = 1'b1;
      tick();
      checks++;
      if (sticky_ovf !== exp_s[3])
         $display("FAIL sticky_set_wins: got %b, want %b", sticky_ovf, exp_s[3]);
      else passes++;
      tick();
      clear_ovf = 1'b0;
      checks++;
      if (sticky_ovf !== exp_s[4] || sticky_ovf !== sticky_m)
         $display("FAIL sticky_clear: got %b, want %b", sticky_ovf, exp_s[4]);
      else passes++;
   endtask

   initial begin
      drive(0, '0, 0, 0, 3'd0, 0);
      test_reset();
      test_zero();
      test_flags();
      test_skid();
      test_back_to_back();
      test_sticky();
      test_random();
      test_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage of the 24-bit ALU. It captures the 24 per-bit results selected by the per-slice `MUX_4to1` instances, together with the adder carry/overflow from the MSB slice and the 3-bit operation selector. It derives the condition flags and presents them downstream through a valid/ready handshake. A two-entry skid buffer decouples the ALU from writeback/branch logic, so a downstream stall never drops a result.

## Interface
Parameters:
- WIDTH, 24, datapath width; all result buses use this width.

Ports (one clock; reset is asynchronous and active-low):
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream result is valid this cycle.
- InReady  output  1  stage can accept; registered.
- Result  input  WIDTH  concatenated mux outputs, bit i from slice i.
- CarryIn  input  1  carry-out of the MSB adder slice.
- OvfIn  input  1  signed overflow of the MSB adder slice.
- Selector  input  3  operation tag, the same encoding driven to the slice muxes.
- OutValid  output  1  entry at head is valid.
- OutReady  input  1  downstream accepts the head entry.
- OutResult  output  WIDTH  head result.
- Zero  output  1  head result equals 0.
- Negative  output  1  head result bit WIDTH-1.
- Carry  output  1  head carry flag.
- Ovf  output  1  head overflow flag.
- IllegalOp  output  1  head entry had Selector 3'b100..3'b111.
- ClearOvf  input  1  clears StickyOvf; only used when ALU_STICKY_OVF_EN is defined.
- StickyOvf  output  1  accumulated overflow.

## Operation
- Accept: when InValid && InReady. Pop: when OutValid && OutReady.
- Flags are computed at accept time and stored with the entry:
  - Zero = (Result == 0).
  - Negative = Result[WIDTH-1].
  - Carry = CarryIn and Ovf = OvfIn only for Selector 3'b010 (add) or 3'b011 (less/subtract). Otherwise both are 0.
  - IllegalOp = Selector[2]. Illegal entries are still accepted and passed through unchanged.
- FSM over occupancy. States are EMPTY, ONE and TWO, each entry holding result plus all flags.
  - EMPTY: accept → ONE (main loaded).
  - ONE:
    - accept with no pop → TWO (skid loaded);
    - accept with pop → ONE (main reloaded);
    - pop only → EMPTY.
  - TWO: pop → ONE, with skid moved to main. No accept is possible because InReady = 0.
- InReady is registered: 1 in EMPTY and ONE, 0 in TWO. It is never combinationally dependent on OutReady.
- OutValid = 1 in ONE and TWO. Outputs always reflect main. Ordering is strictly FIFO.
- While OutValid = 1 and OutReady = 0, the head entry (result and flags) is held stable.

## Timing
- Latency: a result accepted at edge N appears on OutResult/OutValid after edge N, usable in cycle N+1.
- Throughput: one result per cycle while OutReady = 1.
- When TWO is entered, InReady drops for the next cycle.
- Reset (asynchronous, at any time including mid-transfer):
  - state = EMPTY, InReady = 1, OutValid = 0;
  - OutResult = 0, Zero = 0, Negative = 0, Carry = 0, Ovf = 0, IllegalOp = 0, StickyOvf = 0;
  - buffered entries are discarded.
- Simultaneous accept and pop in ONE: the new entry replaces main in the same edge, with no bubble.

## Configuration
- ALU_STICKY_OVF_EN defined:
  - StickyOvf sets on the edge where an entry with Ovf = 1 is popped.
  - ClearOvf clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- ALU_STICKY_OVF_EN undefined:
  - StickyOvf is tied to 0 and ClearOvf is ignored.
  - All other behaviour is identical.

## Test plan
- Reset with Reset=0 mid-stream → outputs as listed under Timing, InReady = 1.
- Accept Result=24'h000000, Selector=3'b000 → next cycle OutValid = 1, Zero = 1, Carry = 0, Ovf = 0.
- Accept Result=24'h800000, CarryIn=1, OvfIn=1, Selector=3'b010 → Negative = 1, Carry = 1, Ovf = 1. Repeat with Selector=3'b001 → Carry = 0, Ovf = 0.
- Hold OutReady=0 and push three results A, B, C:
  - A and B are accepted, InReady = 0 for C, C is held upstream;
  - raise OutReady → A, B, C emerge in order with no loss.
- OutReady=1 continuously with 10 back-to-back accepts → 10 outputs on consecutive cycles, InReady stays 1.
- With ALU_STICKY_OVF_EN: pop an Ovf=1 entry → StickyOvf = 1 and it persists across Ovf=0 pops. Assert ClearOvf in the same cycle as another Ovf=1 pop → StickyOvf stays 1. ClearOvf alone → StickyOvf = 0.
